reg_writeback_arbiter: RTL

Writeback-side producer for the single register-file write port. Merges the in-order pipeline writeback stream, which can never stall, with results from the long-latency multiply/divide unit, which is back-pressured. MDU results are buffered in a small FIFO and written only on cycles the pipeline leaves the port free. A pending-register mask is exported so the hazard unit can stall readers of registers whose MDU result has not yet reached the register file.

---
 rtl/reg_writeback_arbiter_pkg.sv | 13 +
 rtl/reg_writeback_arbiter_wb_fifo.sv | 75 +++++++
 rtl/reg_writeback_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths and the register-file write-port bundle used by the writeback arbiter and the register file.
package reg_writeback_arbiter_pkg;

  localparam int ADDRESS_WIDTH = 5;
  localparam int REGISTER_SIZE = 32;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [REGISTER_SIZE-1:0] data;
    logic                     we;
  } wb_port_t;

endpackage

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// MDU result FIFO: one-cycle push-to-head, pop takes effect at the next edge; full blocks the producer upstream.
// Per-entry valid and rd vectors let the owner build a pending-register mask.
module wb_fifo
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int address_width = ADDRESS_WIDTH,
  parameter int register_size = REGISTER_SIZE,
  parameter int depth         = 4,
  localparam int PW           = $clog2(depth),
  localparam int CW           = PW + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_push,
  input  logic [address_width-1:0]              i_push_rd,
  input  logic [register_size-1:0]              i_push_data,
  input  logic                                  i_pop,
  output logic [address_width-1:0]              o_head_rd,
  output logic [register_size-1:0]              o_head_data,
  output logic [CW-1:0]                         o_count,
  output logic                                  o_full,
  output logic                                  o_empty,
  output logic [depth-1:0]                      o_entry_vld,
  output logic [depth-1:0][address_width-1:0]   o_entry_rd
);

  logic [address_width-1:0] r_rd_mem   [depth];
  logic [register_size-1:0] r_data_mem [depth];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd_mem[r_wr_ptr]   <= i_push_rd;
      r_data_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] w_off;
    w_off       = '0;
    o_entry_vld = '0;
    o_entry_rd  = '0;
    for (int i = 0; i < depth; i++) begin
      w_off          = PW'(i) - r_rd_ptr;
      o_entry_vld[i] = CW'(w_off) < r_count;
      o_entry_rd[i]  = r_rd_mem[i];
    end
  end

  assign o_head_rd   = r_rd_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = r_count == CW'(depth);
  assign o_empty     = r_count == '0;

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single write-port arbiter: pipeline wins, buffered MDU results fill idle slots in order; one registered output stage.
// MDU is back-pressured only by FIFO occupancy; pending_o marks registers with an MDU write not yet committed.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int address_width = ADDRESS_WIDTH,
  parameter int register_size = REGISTER_SIZE,
  parameter int depth         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_valid_i,
  input  logic [address_width-1:0]      pipe_rd_i,
  input  logic [register_size-1:0]      pipe_data_i,
  input  logic                          mdu_valid_i,
  output logic                          mdu_ready_o,
  input  logic [address_width-1:0]      mdu_rd_i,
  input  logic [register_size-1:0]      mdu_data_i,
  output logic [address_width-1:0]      writereg_addr_o,
  output logic [register_size-1:0]      data_o,
  output logic                          data_write_o,
  output logic [2**address_width-1:0]   pending_o
);

  localparam int CW = $clog2(depth) + 1;

  logic                                 w_pipe_hit;
  logic                                 w_mdu_take;
  logic                                 w_push;
  logic                                 w_pop;
  logic                                 w_bypass;
  logic [address_width-1:0]             w_head_rd;
  logic [register_size-1:0]             w_head_data;
  logic [CW-1:0]                        w_count;
  logic                                 w_full;
  logic                                 w_empty;
  logic [depth-1:0]                     w_entry_vld;
  logic [depth-1:0][address_width-1:0]  w_entry_rd;

  logic [address_width-1:0]             r_addr;
  logic [register_size-1:0]             r_data;
  logic                                 r_we;
  logic                                 r_out_is_mdu;

  assign w_pipe_hit  = pipe_valid_i && (pipe_rd_i != '0);
  assign mdu_ready_o = !w_full;
  // rd=0 results are accepted (handshake completes) but dropped here.
  assign w_mdu_take  = mdu_valid_i && mdu_ready_o && (mdu_rd_i != '0);
  assign w_pop       = !w_pipe_hit && !w_empty;
  assign w_bypass    = !w_pipe_hit && w_empty && w_mdu_take;
  assign w_push      = w_mdu_take && !w_bypass;

  wb_fifo #(
    .address_width (address_width),
    .register_size (register_size),
    .depth         (depth)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_rd   (mdu_rd_i),
    .i_push_data (mdu_data_i),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_entry_vld (w_entry_vld),
    .o_entry_rd  (w_entry_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_out_is_mdu <= 1'b0;
    end else if (w_pipe_hit) begin
      r_addr       <= pipe_rd_i;
      r_data       <= pipe_data_i;
      r_we         <= 1'b1;
      r_out_is_mdu <= 1'b0;
    end else if (w_pop) begin
      r_addr       <= w_head_rd;
      r_data       <= w_head_data;
      r_we         <= 1'b1;
      r_out_is_mdu <= 1'b1;
    end else if (w_bypass) begin
      r_addr       <= mdu_rd_i;
      r_data       <= mdu_data_i;
      r_we         <= 1'b1;
      r_out_is_mdu <= 1'b1;
    end else begin
      r_we         <= 1'b0;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < depth; i++) begin
      if (w_entry_vld[i]) pending_o[w_entry_rd[i]] = 1'b1;
    end
    if (r_we && r_out_is_mdu) pending_o[r_addr] = 1'b1;
    pending_o[0] = 1'b0;
  end

  assign writereg_addr_o = r_addr;
  assign data_o          = r_data;
  assign data_write_o    = r_we;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_full && w_push) && (w_count <= CW'(depth)));

endmodule
